// File: rtl/mem_req_if.sv
// Request/bus interface for mem_req_queue.
// Groups the execute-stage request input, the data-memory bus, the
// writeback outputs and the status flags.
//   slave  : view used by mem_req_queue
//   master : view used by whatever drives requests and models the bus
interface mem_req_if;
    logic        in_vld;
    logic [8:0]  in_para;     // {rd[8:4], store[3], funct3[2:0]}
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_rdy;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic        err;
    logic        empty;

    modport slave (
        input  in_vld, in_para, in_addr, in_wdata, dmem_ack, dmem_rdata,
        output in_rdy, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_sel, wb_data, err, empty
    );

    modport master (
        output in_vld, in_para, in_addr, in_wdata, dmem_ack, dmem_rdata,
        input  in_rdy, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_sel, wb_data, err, empty
    );
endinterface

// File: rtl/mem_req_queue.sv
// Memory request queue: buffers load/store requests from the execute stage
// in a DEPTH-entry FIFO and issues them one at a time on the data-memory bus.
// Loads are formatted (lane select, sign/zero extension) and written back
// for one cycle; misaligned or illegal requests are dropped with an err pulse.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-low reset
//   bus  : mem_req_if.slave (request input, dmem bus, writeback, status)
//
// state | meaning
// IDLE  | waiting for a head entry; legal head is dispatched, illegal dropped
// REQ   | dmem_req asserted for the head entry until dmem_ack
// WB    | load result presented on wb_sel/wb_data for one cycle
module mem_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    mem_req_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

    state_t       state;
    logic [8:0]   para_q  [DEPTH];
    logic [31:0]  addr_q  [DEPTH];
    logic [31:0]  wdata_q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]  count;

    logic         req_q, we_q, err_q;
    logic [31:0]  addr_o, wdata_o, wb_data_q;
    logic [3:0]   be_q;
    logic [4:0]   wb_sel_q;

    logic         full, push, pop, have_head, head_bad;
    logic [8:0]   hd_para;
    logic [31:0]  hd_addr, hd_wdata;
    logic [3:0]   st_be;
    logic [31:0]  st_data, ld_shift, ld_data;

    function automatic logic is_illegal(input logic [8:0] p, input logic [1:0] a);
        logic bad_f3, misal;
        if (p[3])
            bad_f3 = (p[2:0] > 3'b010);
        else
            bad_f3 = (p[2:0] == 3'b011) || (p[2:0] == 3'b110) || (p[2:0] == 3'b111);
        misal = ((p[1:0] == 2'b01) && a[0]) || ((p[1:0] == 2'b10) && (a != 2'b00));
        return bad_f3 || misal;
    endfunction

    assign full       = (count == FULL_CNT);
    assign bus.in_rdy = !full;
    assign push       = bus.in_vld && !full;

    // With an empty FIFO the incoming request is treated as the head so an
    // idle queue can dispatch in the same edge that captures the push.
    always_comb begin
        hd_para  = para_q[rd_ptr];
        hd_addr  = addr_q[rd_ptr];
        hd_wdata = wdata_q[rd_ptr];
        if (count == '0) begin
            hd_para  = bus.in_para;
            hd_addr  = bus.in_addr;
            hd_wdata = bus.in_wdata;
        end
    end

    assign have_head = (count != '0) || push;
    assign head_bad  = is_illegal(hd_para, hd_addr[1:0]);

    // Head leaves the FIFO when dropped as illegal or when the bus accepts it.
    assign pop = ((state == IDLE) && have_head && head_bad) ||
                 ((state == REQ) && bus.dmem_ack);

    always_comb begin
        st_be   = 4'b1111;
        st_data = hd_wdata;
        case (hd_para[1:0])
            2'b00: begin
                st_be   = 4'b0001 << hd_addr[1:0];
                st_data = {4{hd_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << hd_addr[1:0];
                st_data = {2{hd_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shift = bus.dmem_rdata >> {hd_addr[1:0], 3'b000};
        case (hd_para[2:0])
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'b0, ld_shift[7:0]};
            3'b101:  ld_data = {16'b0, ld_shift[15:0]};
            default: ld_data = bus.dmem_rdata;
        endcase
    end

    // Entry storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            para_q[wr_ptr]  <= bus.in_para;
            addr_q[wr_ptr]  <= bus.in_addr;
            wdata_q[wr_ptr] <= bus.in_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'b0;
            addr_o    <= '0;
            wdata_o   <= '0;
            err_q     <= 1'b0;
            wb_sel_q  <= '0;
            wb_data_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;

            err_q     <= 1'b0;
            wb_sel_q  <= '0;
            wb_data_q <= '0;

            case (state)
                IDLE: begin
                    if (have_head) begin
                        if (head_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            state   <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= hd_para[3];
                            be_q    <= st_be;
                            addr_o  <= {hd_addr[31:2], 2'b00};
                            wdata_o <= hd_para[3] ? st_data : 32'b0;
                        end
                    end
                end
                REQ: begin
                    if (bus.dmem_ack) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        be_q  <= 4'b0;
                        if (hd_para[3]) begin
                            state <= IDLE;
                        end else begin
                            state     <= WB;
                            wb_sel_q  <= hd_para[8:4];
                            wb_data_q <= ld_data;
                        end
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_be    = be_q;
    assign bus.dmem_addr  = addr_o;
    assign bus.dmem_wdata = wdata_o;
    assign bus.wb_sel     = wb_sel_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.err        = err_q;
    assign bus.empty      = (count == '0) && (state == IDLE);
endmodule

// File: tb/tb_mem_req_queue.sv
// Directed self-checking bench for mem_req_queue (DEPTH = 4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mem_req_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_req_if bus();

    mem_req_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [4:0] rd, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        bus.in_vld   = 1'b1;
        bus.in_para  = {rd, st, f3};
        bus.in_addr  = a;
        bus.in_wdata = d;
    endtask

    // Store into an idle queue: request must appear one cycle after the push.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        drive_req(5'd0, 1'b1, f3, a, d);
        step();
        bus.in_vld = 1'b0;
        check({tag, "_req"},   32'(bus.dmem_req),   32'd1);
        check({tag, "_addr"},  bus.dmem_addr,       exp_addr);
        check({tag, "_be"},    32'(bus.dmem_be),    32'(exp_be));
        check({tag, "_wdata"}, bus.dmem_wdata,      exp_wd);
        check({tag, "_we"},    32'(bus.dmem_we),    32'd1);
        bus.dmem_ack = 1'b1;
        step();
        bus.dmem_ack = 1'b0;
        check({tag, "_req_off"}, 32'(bus.dmem_req), 32'd0);
        check({tag, "_be_off"},  32'(bus.dmem_be),  32'd0);
        check({tag, "_no_wb"},   32'(bus.wb_sel),   32'd0);
        check({tag, "_empty"},   32'(bus.empty),    32'd1);
    endtask

    // Load into an idle queue with ack in the request cycle.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rdata,
                           input logic [31:0] exp_data);
        drive_req(rd, 1'b0, f3, a, 32'h0);
        step();
        bus.in_vld = 1'b0;
        check({tag, "_req"},  32'(bus.dmem_req), 32'd1);
        check({tag, "_we"},   32'(bus.dmem_we),  32'd0);
        check({tag, "_addr"}, bus.dmem_addr,     {a[31:2], 2'b00});
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
        step();
        bus.dmem_ack   = 1'b0;
        check({tag, "_wb_sel"},  32'(bus.wb_sel), 32'(rd));
        check({tag, "_wb_data"}, bus.wb_data,     exp_data);
        check({tag, "_req_off"}, 32'(bus.dmem_req), 32'd0);
        step();
        check({tag, "_wb_sel_clr"},  32'(bus.wb_sel), 32'd0);
        check({tag, "_wb_data_clr"}, bus.wb_data,     32'd0);
        check({tag, "_empty"},       32'(bus.empty),  32'd1);
    endtask

    initial begin
        bus.in_vld     = 1'b0;
        bus.in_para    = '0;
        bus.in_addr    = '0;
        bus.in_wdata   = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;

        // Reset, with a request offered during reset that must not be taken
        rst = 1'b0;
        drive_req(5'd1, 1'b1, 3'b010, 32'h10, 32'h1);
        step();
        step();
        bus.in_vld = 1'b0;
        rst = 1'b1;
        check("rst_req",     32'(bus.dmem_req), 32'd0);
        check("rst_wb_sel",  32'(bus.wb_sel),   32'd0);
        check("rst_wb_data", bus.wb_data,       32'd0);
        check("rst_err",     32'(bus.err),      32'd0);
        check("rst_in_rdy",  32'(bus.in_rdy),   32'd1);
        check("rst_empty",   32'(bus.empty),    32'd1);
        step();
        check("rst_no_capture", 32'(bus.dmem_req), 32'd0);

        // Stores
        do_store("sb", 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
        do_store("sh", 3'b001, 32'h0000_1002, 32'h0000_1234, 32'h0000_1000, 4'b1100, 32'h1234_1234);
        do_store("sw", 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'h0000_2004, 4'b1111, 32'hCAFE_F00D);

        // Loads
        do_load("lb",  5'd5, 3'b000, 32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80);
        do_load("lbu", 5'd5, 3'b100, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080);
        do_load("lh",  5'd9, 3'b001, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu", 5'd9, 3'b101, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
        do_load("lw",  5'd7, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("lb_r0", 5'd0, 3'b000, 32'h0000_0003, 32'h7F00_0000, 32'h0000_007F);

        // Misaligned lw dropped, following sw serviced
        drive_req(5'd4, 1'b0, 3'b010, 32'h0000_3002, 32'h0);
        step();
        drive_req(5'd0, 1'b1, 3'b010, 32'h0000_4000, 32'h5566_7788);
        check("mis_err",  32'(bus.err),      32'd1);
        check("mis_noreq", 32'(bus.dmem_req), 32'd0);
        step();
        bus.in_vld = 1'b0;
        check("mis_err_pulse", 32'(bus.err),  32'd0);
        check("mis_next_req",  32'(bus.dmem_req), 32'd1);
        check("mis_next_addr", bus.dmem_addr,     32'h0000_4000);
        check("mis_next_wd",   bus.dmem_wdata,    32'h5566_7788);
        bus.dmem_ack = 1'b1;
        step();
        bus.dmem_ack = 1'b0;
        check("mis_done_empty", 32'(bus.empty), 32'd1);

        // Illegal store funct3
        drive_req(5'd0, 1'b1, 3'b100, 32'h0000_5000, 32'h1);
        step();
        bus.in_vld = 1'b0;
        check("bad_st_err",   32'(bus.err),      32'd1);
        check("bad_st_noreq", 32'(bus.dmem_req), 32'd0);
        step();
        check("bad_st_empty", 32'(bus.empty), 32'd1);

        // Fill the FIFO with ack held low
        for (int i = 0; i < 4; i++) begin
            drive_req(5'd0, 1'b1, 3'b010, 32'h100 + 32'(4 * i), 32'(i + 1));
            step();
        end
        check("full_in_rdy", 32'(bus.in_rdy), 32'd0);
        drive_req(5'd0, 1'b1, 3'b010, 32'h0000_0200, 32'hEE);
        step();
        step();
        bus.in_vld = 1'b0;
        check("full_still",    32'(bus.in_rdy), 32'd0);
        check("full_head_addr", bus.dmem_addr,  32'h0000_0100);
        check("full_head_wd",   bus.dmem_wdata, 32'h0000_0001);
        bus.dmem_ack = 1'b1;
        step();
        check("pop_in_rdy", 32'(bus.in_rdy),   32'd1);
        check("pop_idle",   32'(bus.dmem_req), 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            check("order_req",   32'(bus.dmem_req), 32'd1);
            check("order_addr",  bus.dmem_addr,     32'h100 + 32'(4 * i));
            check("order_wdata", bus.dmem_wdata,    32'(i + 1));
            step();
            check("order_gap",   32'(bus.dmem_req), 32'd0);
        end
        bus.dmem_ack = 1'b0;
        check("fill_empty", 32'(bus.empty), 32'd1);
        step();
        check("fill_no_extra", 32'(bus.dmem_req), 32'd0);

        // Reset during an outstanding request with more entries queued
        drive_req(5'd3, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
        step();
        drive_req(5'd0, 1'b1, 3'b010, 32'h0000_0600, 32'h9);
        check("rstreq_req", 32'(bus.dmem_req), 32'd1);
        step();
        bus.in_vld = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        check("rstreq_req_off", 32'(bus.dmem_req), 32'd0);
        step();
        bus.dmem_ack = 1'b0;
        check("rstreq_late_ack_req", 32'(bus.dmem_req), 32'd0);
        check("rstreq_wb_sel",       32'(bus.wb_sel),   32'd0);
        check("rstreq_empty",        32'(bus.empty),    32'd1);
        step();
        check("rstreq_quiet", 32'(bus.dmem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
